i2c_cmd_sequencer: RTL and testbench
====================================

Name: i2c_cmd_sequencer

Overview:
Command front-end that sits directly upstream of i2c_master. It queues single-byte I2C transactions (rw, 7-bit addr, data) from a valid/ready producer such as a button/UART decoder. It issues them to the master one at a time and returns one response (read data, NACK, timeout) per command through a valid/ready channel. Commands and responses are strictly in order.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, >=2
TIMEOUT_CYCLES, 2_000_000, clk cycles allowed from m_start to m_done/m_ack_error (20 ms at 100 MHz)

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept; equals !full
cmd_rw  in  1  0=write, 1=read
cmd_addr  in  7  target slave address
cmd_data  in  8  write byte; ignored for reads
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_data  out  8  m_rx_data for reads; 0x00 for writes, NACK or timeout
rsp_rw  out  1  rw of the completed command
rsp_nack  out  1  master reported ack_error
rsp_timeout  out  1  master did not finish within TIMEOUT_CYCLES
m_start  out  1  one-cycle start pulse to i2c_master
m_rw_bit  out  1  to master rw_bit
m_slave_addr  out  7  to master slave_addr
m_tx_data  out  8  to master tx_data
m_rx_data  in  8  from master rx_data
m_busy  in  1  from master busy
m_done  in  1  from master done (pulse)
m_ack_error  in  1  from master ack_error (pulse)
fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy
seq_busy  out  1  FSM not in IDLE
nack_count  out  8  NACKs seen since reset; saturates at 255

Behaviour:
- Reset (async, rst_n low): FSM=IDLE, FIFO empty, all outputs 0 except cmd_ready=1. Queued commands are discarded. Reset mid-transaction is legal because the master shares rst_n.
- FIFO push on cmd_valid && cmd_ready at a clk edge. No bypass: cmd_ready depends only on full, so a simultaneous pop does not admit a push when full. Pop occurs only in IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE: if FIFO is non-empty and !m_busy, pop, latch the entry into m_rw_bit/m_slave_addr/m_tx_data, then go to ISSUE. m_done/m_ack_error pulses arriving in IDLE are ignored (stale after a timeout).
- ISSUE: m_start=1 for exactly this one cycle. Clear the timer, then go to WAIT.
- WAIT: the timer increments each cycle.
  - On m_ack_error: rsp_nack=1, rsp_data=0x00, nack_count+1 (saturating), go to RESP.
  - Else on m_done: rsp_data = rw ? m_rx_data : 0x00, go to RESP.
  - If m_done and m_ack_error arrive together, NACK wins.
  - If the timer reaches TIMEOUT_CYCLES-1 with no completion: rsp_timeout=1, rsp_data=0x00, go to RESP. Completion takes priority over timeout in the same cycle.
- RESP: rsp_valid=1, with rsp_* held stable until rsp_ready. On the handshake edge, rsp_valid=0 and the FSM returns to IDLE.
- m_rw_bit/m_slave_addr/m_tx_data are stable from ISSUE until the next pop.
- Latency: with an empty FIFO and idle FSM, a command accepted at edge N is popped at N+1 and m_start is high in the cycle after N+1. The next m_start comes at the earliest 2 cycles after the previous response handshake.
- Timeout does not abort the master. IDLE's !m_busy check blocks re-issue until the master frees.

Decomposition:
- i2c_pkg holds:
  - packed struct i2c_cmd_t {rw, addr[6:0], data[7:0]}
  - enum seq_state_e {IDLE, ISSUE, WAIT, RESP}
  - constants I2C_WRITE=0, I2C_READ=1
- Sub-module i2c_cmd_fifo: synchronous FIFO of i2c_cmd_t, DEPTH entries, outputs full/empty/count, async active-low reset.

Test Plan:
1. Write cmd (0, 0x55, 0xA5) to real master+slave@0x55 -> single m_start pulse with addr=0x55, tx=0xA5; response rw=0, nack=0, timeout=0, data=0x00; slave rx_data=0xA5.
2. Back-to-back writes 0x10, 0x11, 0x12 then read 0x55 with slave tx=0x3C, rsp_ready=1 -> four responses in order; each m_start only after the prior response; last response data=0x3C.
3. rsp_ready=0, offer 6 cmds with DEPTH=4 -> 5 accepted, cmd_ready=0, fifo_count=4; raise rsp_ready -> all 5 responses drain, fifo_count returns to 0.
4. Write to addr 0x22 -> rsp_nack=1, nack_count 0->1; the following write to 0x55 completes with nack=0.
5. Behavioural master that never pulses done/ack_error, TIMEOUT_CYCLES=100, m_busy held high -> rsp_timeout=1 after 100 cycles in WAIT. The next queued cmd gets no m_start until m_busy falls; a late m_done in IDLE produces no response.
6. Assert rst_n low during WAIT with 2 cmds queued -> outputs immediately at reset values, fifo_count=0; after release no m_start occurs until a new command is pushed.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types for the I2C command sequencer: the queued command word,
// the sequencer state encoding and the read/write flag values.
package i2c_pkg;

   localparam logic I2C_WRITE = 1'b0;
   localparam logic I2C_READ  = 1'b1;

   typedef struct packed {
      logic       rw;
      logic [6:0] addr;
      logic [7:0] data;
   } i2c_cmd_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } seq_state_e;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous FIFO of I2C commands with occupancy count; pointers wrap
// naturally because DEPTH is a power of two.
module i2c_cmd_fifo
   import i2c_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  i2c_cmd_t                 push_data,
   input  logic                     pop,
   output i2c_cmd_t                 pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

   i2c_cmd_t        mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Storage needs no reset: entries are only visible once counted.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues single-byte I2C commands, issues them one at a time to i2c_master
// and returns one in-order response (data, NACK or timeout) per command.
module i2c_cmd_sequencer
   import i2c_pkg::*;
#(
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 2_000_000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_rw,
   input  logic [6:0]               cmd_addr,
   input  logic [7:0]               cmd_data,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [7:0]               rsp_data,
   output logic                     rsp_rw,
   output logic                     rsp_nack,
   output logic                     rsp_timeout,
   output logic                     m_start,
   output logic                     m_rw_bit,
   output logic [6:0]               m_slave_addr,
   output logic [7:0]               m_tx_data,
   input  logic [7:0]               m_rx_data,
   input  logic                     m_busy,
   input  logic                     m_done,
   input  logic                     m_ack_error,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     seq_busy,
   output logic [7:0]               nack_count
);

   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   seq_state_e      state;
   logic [TW-1:0]   timer;
   i2c_cmd_t        push_cmd;
   i2c_cmd_t        head_cmd;
   logic            fifo_full;
   logic            fifo_empty;
   logic            pop;

   assign push_cmd  = {cmd_rw, cmd_addr, cmd_data};
   assign cmd_ready = !fifo_full;
   assign seq_busy  = (state != IDLE);
   // A master still busy from a timed-out command blocks the next issue.
   assign pop       = (state == IDLE) && !fifo_empty && !m_busy;

   i2c_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (cmd_valid),
      .push_data (push_cmd),
      .pop       (pop),
      .pop_data  (head_cmd),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         timer        <= '0;
         m_start      <= 1'b0;
         m_rw_bit     <= 1'b0;
         m_slave_addr <= '0;
         m_tx_data    <= '0;
         rsp_valid    <= 1'b0;
         rsp_data     <= '0;
         rsp_rw       <= 1'b0;
         rsp_nack     <= 1'b0;
         rsp_timeout  <= 1'b0;
         nack_count   <= '0;
      end else begin
         m_start <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  m_rw_bit     <= head_cmd.rw;
                  m_slave_addr <= head_cmd.addr;
                  m_tx_data    <= head_cmd.data;
                  m_start      <= 1'b1;
                  state        <= ISSUE;
               end
            end
            ISSUE: begin
               timer       <= '0;
               rsp_nack    <= 1'b0;
               rsp_timeout <= 1'b0;
               rsp_data    <= '0;
               state       <= WAIT;
            end
            // NACK beats done, and any completion beats the timeout.
            WAIT: begin
               if (m_ack_error) begin
                  rsp_nack   <= 1'b1;
                  rsp_data   <= '0;
                  rsp_rw     <= m_rw_bit;
                  rsp_valid  <= 1'b1;
                  nack_count <= (nack_count == 8'hFF) ? nack_count : nack_count + 8'd1;
                  state      <= RESP;
               end else if (m_done) begin
                  rsp_data  <= (m_rw_bit == I2C_READ) ? m_rx_data : 8'h00;
                  rsp_rw    <= m_rw_bit;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else if (timer == TIMER_LAST) begin
                  rsp_timeout <= 1'b1;
                  rsp_data    <= '0;
                  rsp_rw      <= m_rw_bit;
                  rsp_valid   <= 1'b1;
                  state       <= RESP;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Randomized scoreboard bench for i2c_cmd_sequencer with a behavioural
// I2C master/slave model and an address-based response reference model.
module tb_i2c_cmd_sequencer;
   import i2c_pkg::*;

   localparam int DEPTH = 4;
   localparam int T     = 40;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam logic [6:0] NACK_ADDR = 7'h22;
   localparam logic [6:0] HANG_ADDR = 7'h7E;

   typedef struct packed {
      logic       rw;
      logic       nack;
      logic       timeout;
      logic [7:0] data;
   } rsp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_rw;
   logic [6:0]    cmd_addr;
   logic [7:0]    cmd_data;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [7:0]    rsp_data;
   logic          rsp_rw;
   logic          rsp_nack;
   logic          rsp_timeout;
   logic          m_start;
   logic          m_rw_bit;
   logic [6:0]    m_slave_addr;
   logic [7:0]    m_tx_data;
   logic [7:0]    m_rx_data;
   logic          m_busy;
   logic          m_done;
   logic          m_ack_error;
   logic [CW-1:0] fifo_count;
   logic          seq_busy;
   logic [7:0]    nack_count;

   int checks   = 0;
   int failures = 0;

   i2c_cmd_t exp_issue [$];
   i2c_cmd_t exp_rsp   [$];
   int       exp_nacks     = 0;
   int       issued_cnt    = 0;
   int       responded_cnt = 0;
   bit       ready_random  = 1'b0;
   logic     ready_fixed   = 1'b1;

   always #5 clk = ~clk;

   i2c_cmd_sequencer #(
      .DEPTH          (DEPTH),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_rw       (cmd_rw),
      .cmd_addr     (cmd_addr),
      .cmd_data     (cmd_data),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_rw       (rsp_rw),
      .rsp_nack     (rsp_nack),
      .rsp_timeout  (rsp_timeout),
      .m_start      (m_start),
      .m_rw_bit     (m_rw_bit),
      .m_slave_addr (m_slave_addr),
      .m_tx_data    (m_tx_data),
      .m_rx_data    (m_rx_data),
      .m_busy       (m_busy),
      .m_done       (m_done),
      .m_ack_error  (m_ack_error),
      .fifo_count   (fifo_count),
      .seq_busy     (seq_busy),
      .nack_count   (nack_count)
   );

   function automatic logic [7:0] slave_read_byte(input logic [6:0] a);
      return (a == 7'h55) ? 8'h3C : ({1'b0, a} ^ 8'hA5);
   endfunction

   // What the system as a whole must answer for a command, from its address.
   function automatic rsp_t model_rsp(input i2c_cmd_t c);
      rsp_t r;
      r = '0;
      r.rw = c.rw;
      if (c.addr == HANG_ADDR)      r.timeout = 1'b1;
      else if (c.addr == NACK_ADDR) r.nack = 1'b1;
      else if (c.rw == I2C_READ)    r.data = slave_read_byte(c.addr);
      return r;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Master/slave model: NACK_ADDR is absent, HANG_ADDR finishes far too late.
   logic [6:0] mst_addr;
   int         mst_lat;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy      <= 1'b0;
         m_done      <= 1'b0;
         m_ack_error <= 1'b0;
         m_rx_data   <= 8'h00;
         mst_addr    <= 7'h00;
         mst_lat     <= 0;
      end else begin
         m_done      <= 1'b0;
         m_ack_error <= 1'b0;
         if (m_start) begin
            m_busy    <= 1'b1;
            mst_addr  <= m_slave_addr;
            m_rx_data <= slave_read_byte(m_slave_addr);
            mst_lat   <= (m_slave_addr == HANG_ADDR) ? T + 5 + $urandom_range(0, 20)
                                                     : $urandom_range(2, 18);
         end else if (m_busy) begin
            if (mst_lat == 0) begin
               m_busy <= 1'b0;
               if (mst_addr == NACK_ADDR) begin
                  m_ack_error <= 1'b1;
                  m_done      <= 1'($urandom_range(0, 1));
               end else begin
                  m_done <= 1'b1;
               end
            end else begin
               mst_lat <= mst_lat - 1;
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (ready_random) rsp_ready = ($urandom_range(0, 9) < 7);
      else              rsp_ready = ready_fixed;
   end

   // Monitor: checks issues and responses against the queues as they appear.
   logic     prev_start;
   logic     prev_rsp_valid;
   logic     holding;
   rsp_t     held_r;
   rsp_t     exp_r;
   i2c_cmd_t mon_c;
   int       since_start;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_start     = 1'b0;
         prev_rsp_valid = 1'b0;
         holding        = 1'b0;
         since_start    = 0;
      end else begin
         if (m_start) begin
            check_output("start_width", {31'b0, prev_start}, 0);
            check_output("start_while_busy", {31'b0, m_busy}, 0);
            check_output("start_outstanding", issued_cnt, responded_cnt);
            if (exp_issue.size() == 0) begin
               check_output("issue_unexpected", exp_issue.size(), 1);
            end else begin
               mon_c = exp_issue.pop_front();
               check_output("issue_cmd", {15'b0, m_rw_bit, m_slave_addr, m_tx_data}, {15'b0, mon_c});
            end
            issued_cnt++;
            since_start = 0;
         end else begin
            since_start++;
         end
         if (rsp_valid && !prev_rsp_valid && rsp_timeout) begin
            check_output("timeout_latency", since_start, T + 1);
         end
         if (rsp_valid && holding) begin
            check_output("rsp_stable", {21'b0, rsp_rw, rsp_nack, rsp_timeout, rsp_data}, {21'b0, held_r});
         end
         if (rsp_valid && rsp_ready) begin
            holding = 1'b0;
            if (exp_rsp.size() == 0) begin
               check_output("rsp_unexpected", exp_rsp.size(), 1);
            end else begin
               mon_c = exp_rsp.pop_front();
               exp_r = model_rsp(mon_c);
               check_output("rsp", {21'b0, rsp_rw, rsp_nack, rsp_timeout, rsp_data}, {21'b0, exp_r});
               if (exp_r.nack && exp_nacks < 255) exp_nacks++;
            end
            responded_cnt++;
         end else if (rsp_valid) begin
            holding = 1'b1;
            held_r  = {rsp_rw, rsp_nack, rsp_timeout, rsp_data};
         end
         prev_start     = m_start;
         prev_rsp_valid = rsp_valid;
      end
   end

   task automatic apply_stimulus(input logic rw, input logic [6:0] addr, input logic [7:0] data);
      i2c_cmd_t c;
      bit ok;
      c  = {rw, addr, data};
      ok = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_rw    = rw;
      cmd_addr  = addr;
      cmd_data  = data;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1'b1;
            exp_issue.push_back(c);
            exp_rsp.push_back(c);
            break;
         end
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (!ok) check_output("push_accept", {31'b0, ok}, 1);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_rsp.size() != 0 || seq_busy || fifo_count != '0) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check_output({name, "_drain"}, exp_rsp.size(), 0);
   endtask

   task automatic check_reset_values(input string name);
      check_output({name, "_cmd_ready"}, {31'b0, cmd_ready}, 1);
      check_output({name, "_rsp_valid"}, {31'b0, rsp_valid}, 0);
      check_output({name, "_fifo_count"}, {29'b0, fifo_count}, 0);
      check_output({name, "_seq_busy"}, {31'b0, seq_busy}, 0);
      check_output({name, "_m_start"}, {31'b0, m_start}, 0);
      check_output({name, "_nack_count"}, {24'b0, nack_count}, 0);
      check_output({name, "_rsp_flags"}, {22'b0, rsp_nack, rsp_timeout, rsp_data}, 0);
      check_output({name, "_m_addr"}, {25'b0, m_slave_addr}, 0);
   endtask

   initial begin
      #800000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [6:0] a;
      int r;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_rw    = 1'b0;
      cmd_addr  = '0;
      cmd_data  = '0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      $display("[TB] single write");
      apply_stimulus(I2C_WRITE, 7'h55, 8'hA5);
      wait_drain("write55");

      $display("[TB] back-to-back writes then read");
      apply_stimulus(I2C_WRITE, 7'h10, 8'h01);
      apply_stimulus(I2C_WRITE, 7'h11, 8'h02);
      apply_stimulus(I2C_WRITE, 7'h12, 8'h03);
      apply_stimulus(I2C_READ,  7'h55, 8'h00);
      wait_drain("b2b");

      $display("[TB] fill with response backpressure");
      ready_fixed = 1'b0;
      for (int i = 0; i < 5; i++) apply_stimulus(I2C_WRITE, 7'h30 + 7'(i), 8'(i * 17));
      repeat (30) @(negedge clk);
      check_output("fill_count", {29'b0, fifo_count}, DEPTH);
      check_output("fill_ready", {31'b0, cmd_ready}, 0);
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_addr  = 7'h3F;
      repeat (6) begin
         @(negedge clk);
         check_output("full_refuses", {31'b0, cmd_ready}, 0);
      end
      @(posedge clk); #1;
      cmd_valid   = 1'b0;
      ready_fixed = 1'b1;
      wait_drain("fill");
      check_output("fill_empty", {29'b0, fifo_count}, 0);

      $display("[TB] nack then good write");
      apply_stimulus(I2C_WRITE, NACK_ADDR, 8'h77);
      apply_stimulus(I2C_WRITE, 7'h55, 8'h12);
      wait_drain("nack");
      check_output("nack_count", {24'b0, nack_count}, exp_nacks);

      $display("[TB] timeout then queued write");
      apply_stimulus(I2C_READ, HANG_ADDR, 8'h00);
      apply_stimulus(I2C_WRITE, 7'h55, 8'h9A);
      wait_drain("timeout");

      $display("[TB] randomized traffic");
      ready_random = 1'b1;
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 11);
         if (r == 0)      a = NACK_ADDR;
         else if (r == 1) a = HANG_ADDR;
         else begin
            a = 7'($urandom_range(0, 127));
            if (a == NACK_ADDR || a == HANG_ADDR) a = 7'h55;
         end
         apply_stimulus(1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)));
      end
      wait_drain("random");
      ready_random = 1'b0;
      check_output("nack_count_rand", {24'b0, nack_count}, exp_nacks);

      $display("[TB] reset during wait");
      apply_stimulus(I2C_WRITE, HANG_ADDR, 8'h01);
      apply_stimulus(I2C_WRITE, 7'h10, 8'h02);
      apply_stimulus(I2C_WRITE, 7'h11, 8'h03);
      r = 0;
      while (!(seq_busy && fifo_count == CW'(2) && !rsp_valid) && r < 200) begin
         @(negedge clk);
         r++;
      end
      check_output("reset_setup_queued", {29'b0, fifo_count}, 2);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #2;
      check_reset_values("midreset");
      exp_issue.delete();
      exp_rsp.delete();
      exp_nacks     = 0;
      issued_cnt    = 0;
      responded_cnt = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check_output("no_start_after_reset", issued_cnt, 0);
      check_output("idle_after_reset", {31'b0, seq_busy}, 0);

      $display("[TB] nack counter saturation");
      for (int i = 0; i < 260; i++) apply_stimulus(I2C_WRITE, NACK_ADDR, 8'(i));
      wait_drain("saturate");
      check_output("nack_saturate", {24'b0, nack_count}, 255);
      check_output("nack_model", {24'b0, nack_count}, exp_nacks);

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
